// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector datapath blocks.
package mvm_pkg;

  localparam int unsigned MVM_N = 8;

  typedef logic [MVM_N-1:0] elem_t;

  localparam elem_t N_MAX = '1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Unsigned saturating add; returns {carry, clamped sum}.
  function automatic logic [MVM_N:0] sat_add(input elem_t a, input elem_t b);
    logic [MVM_N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[MVM_N]) begin
      return {1'b1, N_MAX};
    end
    return s;
  endfunction

endpackage

// File: rtl/mvm_sat_add.sv
// Combinational N-bit unsigned saturating adder with overflow flag.
module mvm_sat_add #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N:0] sum_wide;

  // Widen by one bit; clamp to all-ones when the top bit overflows.
  always_comb begin
    sum_wide = {1'b0, a_i} + {1'b0, b_i};
    carry_o  = sum_wide[N];
    sum_o    = sum_wide[N] ? '1 : sum_wide[N-1:0];
  end

endmodule

// File: rtl/mvm_row_accumulator.sv
// Accumulates CHUNKS saturated chunk results into one row result and
// presents it with a row index over a valid/ready handshake.
module mvm_row_accumulator
  import mvm_pkg::*;
#(
  parameter int unsigned N      = MVM_N,
  parameter int unsigned CHUNKS = 4,
  parameter int unsigned ROWS   = 4,
  localparam int unsigned CW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          out_sat
);

  localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  acc_state_e    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          sat_q, sat_d;

  logic [N-1:0]  add_sum;
  logic          add_carry;

  mvm_sat_add #(
    .N(N)
  ) u_sat_add (
    .a_i    (acc_q),
    .b_i    (in_data),
    .sum_o  (add_sum),
    .carry_o(add_carry)
  );

  // State, accumulator, counters and saturation flag registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state: accumulate chunks in ACCUM, present the row in HOLD.
  // flush takes priority over both a chunk accept and a result handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    sat_d   = sat_q;
    unique case (state_q)
      ACCUM: begin
        if (flush) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          if (cnt_q == '0) begin
            acc_d = in_data;
            sat_d = 1'b0;
          end else begin
            acc_d = add_sum;
            sat_d = sat_q | add_carry;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = ACCUM;
        end else if (out_ready) begin
          state_d = ACCUM;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Handshake and result outputs decoded from registered state.
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
    out_data  = acc_q;
    out_row   = row_q;
    out_last  = (row_q == ROW_LAST);
    out_sat   = sat_q;
  end

endmodule
